// File: rtl/ab_exec_pkg.sv
// ab_exec_pkg
//   Shared definitions for the A/B execution unit: opcode encodings and
//   the controller state encoding. Imported by ab_alu and ab_exec_unit.
package ab_exec_pkg;

  // Opcode encodings (3-bit op field)
  localparam logic [2:0] OP_XOR  = 3'b000;
  localparam logic [2:0] OP_SHR  = 3'b001;
  localparam logic [2:0] OP_MOV  = 3'b010;
  localparam logic [2:0] OP_EXCH = 3'b011;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_SUB  = 3'b101;
  localparam logic [2:0] OP_OR   = 3'b110;
  localparam logic [2:0] OP_AND  = 3'b111;

  // Controller state: IDLE accepts work, SHIFT runs a multi-cycle SHR
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/ab_alu.sv
// ab_alu
//   Combinational result logic for every single-cycle instruction.
//   SHR is passed through unchanged here (the shamt=0 case); multi-bit
//   shifts are sequenced by the top level.
// Ports:
//   op       in   3      opcode
//   ra, rb   in   WIDTH  current architectural registers
//   next_ra  out  WIDTH  value to write into RA
//   next_rb  out  WIDTH  value to write into RB
//   carry    out  1      carry / borrow flag (0 for logic/move ops)
//   zero     out  1      zero flag of the written result
module ab_alu
  import ab_exec_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] ra,
  input  logic [WIDTH-1:0] rb,
  output logic [WIDTH-1:0] next_ra,
  output logic [WIDTH-1:0] next_rb,
  output logic             carry,
  output logic             zero
);

  // Extended-width sum/difference: the top bit is carry-out for ADD and
  // the borrow (ra < rb unsigned) for SUB.
  logic [WIDTH:0] sum_ext;
  logic [WIDTH:0] diff_ext;

  assign sum_ext  = {1'b0, ra} + {1'b0, rb};
  assign diff_ext = {1'b0, ra} - {1'b0, rb};

  always_comb begin
    next_ra = ra;
    next_rb = rb;
    carry   = 1'b0;
    case (op)
      OP_ADD: begin
        next_ra = sum_ext[WIDTH-1:0];
        carry   = sum_ext[WIDTH];
      end
      OP_SUB: begin
        next_ra = diff_ext[WIDTH-1:0];
        carry   = diff_ext[WIDTH];
      end
      OP_OR:   next_ra = ra | rb;
      OP_AND:  next_ra = ra & rb;
      OP_XOR:  next_ra = ra ^ rb;
      OP_MOV:  next_rb = ra;
      OP_EXCH: begin
        next_ra = rb;
        next_rb = ra;
      end
      default: begin
        // OP_SHR with zero shift amount: registers unchanged, carry 0
        next_ra = ra;
        next_rb = rb;
      end
    endcase
  end

  // MOV is the only op whose meaningful result lands in RB
  assign zero = (op == OP_MOV) ? (next_rb == '0) : (next_ra == '0);

endmodule

// File: rtl/ab_exec_unit.sv
// ab_exec_unit
//   Two-register (RA/RB) execution unit. Instructions arrive on a
//   valid/ready handshake; most retire in one cycle, SHR with a non-zero
//   shift amount shifts RA right one bit per cycle. Direct loads of RA/RB
//   are honoured only while idle and take priority over instructions.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   in_valid        instruction present on op/shamt
//   in_ready        unit can accept an instruction this cycle
//   op, shamt       opcode and SHR shift amount
//   ld_a, ld_b      load RA / RB from ld_data (idle only)
//   ld_data         load value
//   ra, rb          architectural registers
//   done            one-cycle pulse per retired instruction
//   carry, zero     flags of the last retired instruction
module ab_exec_unit
  import ab_exec_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         op,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               ld_a,
  input  logic               ld_b,
  input  logic [WIDTH-1:0]   ld_data,
  output logic [WIDTH-1:0]   ra,
  output logic [WIDTH-1:0]   rb,
  output logic               done,
  output logic               carry,
  output logic               zero
);

  state_t             state_q, state_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]   ra_q, ra_d;
  logic [WIDTH-1:0]   rb_q, rb_d;
  logic               done_q, done_d;
  logic               carry_q, carry_d;
  logic               zero_q, zero_d;

  logic [WIDTH-1:0]   alu_ra;
  logic [WIDTH-1:0]   alu_rb;
  logic               alu_carry;
  logic               alu_zero;
  logic [WIDTH-1:0]   ra_shifted;
  logic               accept;

  ab_alu #(
    .WIDTH(WIDTH)
  ) u_alu (
    .op      (op),
    .ra      (ra_q),
    .rb      (rb_q),
    .next_ra (alu_ra),
    .next_rb (alu_rb),
    .carry   (alu_carry),
    .zero    (alu_zero)
  );

  // Pending loads block instructions so a load and an instruction never
  // both target RA/RB at the same edge.
  assign in_ready   = (state_q == IDLE) && !ld_a && !ld_b;
  assign accept     = in_valid && in_ready;
  assign ra_shifted = ra_q >> 1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (ld_a || ld_b) begin
          if (ld_a) ra_d = ld_data;
          if (ld_b) rb_d = ld_data;
        end else if (accept) begin
          if ((op == OP_SHR) && (shamt != '0)) begin
            state_d = SHIFT;
            cnt_d   = shamt;
          end else begin
            ra_d    = alu_ra;
            rb_d    = alu_rb;
            carry_d = alu_carry;
            zero_d  = alu_zero;
            done_d  = 1'b1;
          end
        end
      end
      SHIFT: begin
        // One bit per cycle; carry tracks the bit just shifted out
        ra_d    = ra_shifted;
        carry_d = ra_q[0];
        cnt_d   = cnt_q - 1'b1;
        if (cnt_q == SHAMT_W'(1)) begin
          state_d = IDLE;
          zero_d  = (ra_shifted == '0);
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      done_q  <= 1'b0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      done_q  <= done_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
    end
  end

  assign ra    = ra_q;
  assign rb    = rb_q;
  assign done  = done_q;
  assign carry = carry_q;
  assign zero  = zero_q;

endmodule

// File: tb/tb_ab_exec_unit.sv
// Self-checking bench for ab_exec_unit: directed sequences followed by
// randomized instructions and loads. Expected retirements are queued by
// the driver from a reference model; a monitor checks each done pulse.
module tb_ab_exec_unit;

  localparam logic [2:0] T_XOR  = 3'b000;
  localparam logic [2:0] T_SHR  = 3'b001;
  localparam logic [2:0] T_MOV  = 3'b010;
  localparam logic [2:0] T_EXCH = 3'b011;
  localparam logic [2:0] T_ADD  = 3'b100;
  localparam logic [2:0] T_SUB  = 3'b101;
  localparam logic [2:0] T_OR   = 3'b110;
  localparam logic [2:0] T_AND  = 3'b111;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [3:0]  shamt;
  logic        ld_a;
  logic        ld_b;
  logic [15:0] ld_data;
  logic [15:0] ra;
  logic [15:0] rb;
  logic        done;
  logic        carry;
  logic        zero;

  ab_exec_unit #(
    .WIDTH   (16),
    .SHAMT_W (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .shamt    (shamt),
    .ld_a     (ld_a),
    .ld_b     (ld_b),
    .ld_data  (ld_data),
    .ra       (ra),
    .rb       (rb),
    .done     (done),
    .carry    (carry),
    .zero     (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [15:0] ra;
    logic [15:0] rb;
    logic        c;
    logic        z;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  // Reference architectural state
  logic [15:0] m_ra, m_rb;
  logic        m_c, m_z;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Architectural meaning of each instruction, in plain arithmetic
  task automatic model_exec(input logic [2:0] o, input logic [3:0] s);
    logic [16:0] wide;
    logic [15:0] tmp;
    case (o)
      T_ADD: begin
        wide = 17'(m_ra) + 17'(m_rb);
        m_ra = wide[15:0];
        m_c  = wide[16];
      end
      T_SUB: begin
        m_c  = (m_ra < m_rb);
        m_ra = m_ra - m_rb;
      end
      T_OR:  begin m_ra = m_ra | m_rb; m_c = 1'b0; end
      T_AND: begin m_ra = m_ra & m_rb; m_c = 1'b0; end
      T_XOR: begin m_ra = m_ra ^ m_rb; m_c = 1'b0; end
      T_MOV: begin m_rb = m_ra; m_c = 1'b0; end
      T_EXCH: begin
        tmp  = m_ra;
        m_ra = m_rb;
        m_rb = tmp;
        m_c  = 1'b0;
      end
      default: begin // SHR
        if (s == 0) begin
          m_c = 1'b0;
        end else begin
          tmp  = m_ra >> (s - 1);
          m_c  = tmp[0];
          m_ra = m_ra >> s;
        end
      end
    endcase
    m_z = (o == T_MOV) ? (m_rb == 16'h0) : (m_ra == 16'h0);
  endtask

  // Monitor: every done pulse must match the oldest queued retirement
  always @(negedge clk) begin
    if (!rst && done) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 expected no retirement (cyc=%0d)", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        $display("retire cyc=%0d ra=%04h rb=%04h carry=%0b zero=%0b", cyc, ra, rb, carry, zero);
        check("done_cycle", cyc, e.cyc);
        check("ret_ra", ra, e.ra);
        check("ret_rb", rb, e.rb);
        check("ret_carry", carry, e.c);
        check("ret_zero", zero, e.z);
      end
    end
  end

  // Called at a negedge; returns at a negedge with the load applied
  task automatic do_load(input logic a, input logic b, input logic [15:0] d, input logic with_valid);
    ld_a     = a;
    ld_b     = b;
    ld_data  = d;
    in_valid = with_valid;
    op       = 3'($urandom);
    shamt    = 4'($urandom);
    #1;
    check("ready_during_load", in_ready, 1'b0);
    @(posedge clk);
    @(negedge clk);
    ld_a     = 1'b0;
    ld_b     = 1'b0;
    in_valid = 1'b0;
    if (a) m_ra = d;
    if (b) m_rb = d;
    $display("load a=%0b b=%0b data=%04h ra=%04h rb=%04h", a, b, d, ra, rb);
    check("load_ra", ra, m_ra);
    check("load_rb", rb, m_rb);
    check("load_carry", carry, m_c);
    check("load_zero", zero, m_z);
  endtask

  // Called at a negedge; returns at the negedge after the unit is idle again
  task automatic issue(input logic [2:0] o, input logic [3:0] s);
    exp_t e;
    int   lat;
    lat      = (o == T_SHR) ? int'(s) : 0;
    in_valid = 1'b1;
    op       = o;
    shamt    = s;
    #1;
    check("ready_idle", in_ready, 1'b1);
    model_exec(o, s);
    e.cyc = cyc + 1 + lat;
    e.ra  = m_ra;
    e.rb  = m_rb;
    e.c   = m_c;
    e.z   = m_z;
    q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    // While shifting, throw junk loads at the unit; they must be ignored
    for (int i = 0; i < lat; i++) begin
      ld_a    = 1'($urandom);
      ld_b    = 1'($urandom);
      ld_data = 16'($urandom);
      #1;
      check("ready_busy", in_ready, 1'b0);
      @(negedge clk);
    end
    ld_a = 1'b0;
    ld_b = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && q.size() > 0; i++) @(negedge clk);
    check("drain_queue_empty", q.size(), 0);
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    op       = 3'b000;
    shamt    = 4'h0;
    ld_a     = 1'b0;
    ld_b     = 1'b0;
    ld_data  = 16'h0;
    m_ra = 16'h0; m_rb = 16'h0; m_c = 1'b0; m_z = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ra", ra, 16'h0);
    check("rst_rb", rb, 16'h0);
    check("rst_done", done, 1'b0);
    check("rst_carry", carry, 1'b0);
    check("rst_zero", zero, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", in_ready, 1'b1);

    // Loads
    do_load(1'b1, 1'b0, 16'h1234, 1'b0);
    do_load(1'b0, 1'b1, 16'h00FF, 1'b0);

    // ADD with carry out and zero result
    do_load(1'b1, 1'b0, 16'hFFFF, 1'b0);
    do_load(1'b0, 1'b1, 16'h0001, 1'b0);
    issue(T_ADD, 4'h0);
    @(negedge clk);
    check("done_one_cycle", done, 1'b0);

    // SUB borrow, EXCH, MOV
    do_load(1'b1, 1'b1, 16'h0005, 1'b0);
    do_load(1'b1, 1'b0, 16'h0003, 1'b0);
    issue(T_SUB, 4'h0);
    issue(T_EXCH, 4'h0);
    issue(T_MOV, 4'h0);

    // Multi-cycle and zero-length SHR
    do_load(1'b1, 1'b0, 16'h8001, 1'b0);
    issue(T_SHR, 4'd4);
    @(negedge clk);
    check("shr4_ra", ra, 16'h0800);
    issue(T_SHR, 4'd0);

    // Load and instruction together: load wins, no retirement
    do_load(1'b1, 1'b0, 16'h0F0F, 1'b1);
    do_load(1'b0, 1'b1, 16'h00FF, 1'b1);

    // Three back-to-back XORs
    issue(T_XOR, 4'h0);
    issue(T_XOR, 4'h0);
    issue(T_XOR, 4'h0);
    @(negedge clk);
    drain();

    // Randomized mix
    for (int n = 0; n < 80; n++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 2) begin
        logic la, lb;
        la = 1'($urandom);
        lb = la ? 1'($urandom) : 1'b1;
        do_load(la, lb, (r == 0) ? 16'h0 : 16'($urandom), 1'($urandom));
      end else begin
        logic [2:0] o;
        o = 3'($urandom);
        issue(o, (o == T_SHR) ? 4'($urandom) : 4'h0);
      end
    end
    @(negedge clk);
    drain();

    // Asynchronous reset in the middle of a long shift
    do_load(1'b1, 1'b1, 16'hFFFF, 1'b0);
    in_valid = 1'b1;
    op       = T_SHR;
    shamt    = 4'd15;
    #1;
    check("ready_before_long_shr", in_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    $display("reset mid-shift ra=%04h rb=%04h", ra, rb);
    check("midrst_ra", ra, 16'h0);
    check("midrst_rb", rb, 16'h0);
    check("midrst_carry", carry, 1'b0);
    check("midrst_zero", zero, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_ready", in_ready, 1'b1);
    m_ra = 16'h0; m_rb = 16'h0; m_c = 1'b0; m_z = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("post_rst_ready", in_ready, 1'b1);
    check("post_rst_ra", ra, 16'h0);

    // Unit still works after the abort
    do_load(1'b1, 1'b0, 16'h00F0, 1'b0);
    issue(T_SHR, 4'd4);
    @(negedge clk);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
